// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a classic 5-stage in-order core.
// Resolves memory back-pressure, taken-branch flushes (with optional
// multi-cycle IF/ID flush) and single-cycle load-use stalls. All control
// outputs are combinational from the registered state and the current
// inputs, so they take effect in the same cycle. Two saturating counters
// track stall cycles and accepted branch flushes.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,   // IF/ID flush length per taken branch, 1..4
    parameter int CNT_W        = 16   // width of each performance counter
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    // Extra flush cycles that follow the branch-acceptance cycle itself.
    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_next;
    logic             r_pend_flush;
    logic             w_pend_next;
    logic [2:0]       r_flush_ctr;
    logic [2:0]       w_flush_ctr_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_inc;
    logic             w_flush_inc;
    logic             w_lu_raw;
    logic             w_lu;
    logic             w_branch;
    logic             w_flush_cont;

    // Load-use detection; x0 never carries a real dependency.
    always_comb begin
        w_lu_raw = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (ex_rd == id_rs1)) ||
                    (id_use_rs2 && (ex_rd == id_rs2)));
        // The cycle after a load-use stall the load has moved on, but the
        // ID instruction is unchanged; suppress so each hazard stalls once.
        w_lu         = w_lu_raw && (r_state != LU_STALL);
        w_branch     = branch_taken || r_pend_flush;
        // The flush down-counter, not the state, carries an in-progress
        // flush so that it survives an intervening memory wait.
        w_flush_cont = (r_flush_ctr != 3'd0);
    end

    // Next-state and control-output decode, highest priority first.
    always_comb begin
        pc_write         = 1'b1;
        ifid_write       = 1'b1;
        ifid_flush       = 1'b0;
        idex_bubble      = 1'b0;
        pipe_hold        = 1'b0;
        w_state_next     = RUN;
        w_pend_next      = r_pend_flush;
        w_flush_ctr_next = r_flush_ctr;
        w_stall_inc      = 1'b0;
        w_flush_inc      = 1'b0;

        if (reset) begin
            // Outputs stay idle; register clearing happens in the state flops.
            w_pend_next      = 1'b0;
            w_flush_ctr_next = 3'd0;
        end else if (mem_busy) begin
            // Whole pipe freezes; a branch seen now is remembered for later.
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            pipe_hold    = 1'b1;
            w_state_next = MEM_WAIT;
            w_pend_next  = r_pend_flush || branch_taken;
            w_stall_inc  = 1'b1;
        end else if (w_branch) begin
            // Redirect: kill the fetched instruction and bubble the ID one.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            w_pend_next = 1'b0;
            w_flush_inc = 1'b1;
            if (MULTI_FLUSH) begin
                w_state_next     = FLUSH;
                w_flush_ctr_next = FLUSH_LOAD;
            end else begin
                w_state_next     = RUN;
                w_flush_ctr_next = 3'd0;
            end
        end else if (w_flush_cont) begin
            // Trailing flush cycles: only IF/ID is cleared, ID/EX flows.
            ifid_flush       = 1'b1;
            w_flush_ctr_next = r_flush_ctr - 3'd1;
            w_state_next     = (r_flush_ctr == 3'd1) ? RUN : FLUSH;
        end else if (w_lu) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            w_state_next = LU_STALL;
            w_stall_inc  = 1'b1;
        end else begin
            w_state_next = RUN;
        end
    end

    // State, pending-flush and flush down-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_pend_flush <= 1'b0;
            r_flush_ctr  <= 3'd0;
        end else begin
            r_state      <= w_state_next;
            r_pend_flush <= w_pend_next;
            r_flush_ctr  <= w_flush_ctr_next;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench. Two instances share stimulus:
// u_a uses defaults (FLUSH_CYCLES=1, CNT_W=16), u_b uses FLUSH_CYCLES=3 and
// CNT_W=4. The driver pushes the hand-computed expectation for each cycle;
// a monitor on the falling edge pops and compares.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, branch_taken, mem_busy;

    logic        a_pc, a_ifw, a_fl, a_bub, a_hold;
    logic [15:0] a_stall, a_flush;
    logic        b_pc, b_ifw, b_fl, b_bub, b_hold;
    logic [3:0]  b_stall, b_flush;

    hazard_ctrl u_a (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(a_pc), .ifid_write(a_ifw), .ifid_flush(a_fl),
        .idex_bubble(a_bub), .pipe_hold(a_hold),
        .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(b_pc), .ifid_write(b_ifw), .ifid_flush(b_fl),
        .idex_bubble(b_bub), .pipe_hold(b_hold),
        .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    // Control vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
    localparam logic [4:0] IDLE = 5'b11000;
    localparam logic [4:0] LU   = 5'b00010;
    localparam logic [4:0] BR   = 5'b11110;
    localparam logic [4:0] FL   = 5'b11100;
    localparam logic [4:0] MB   = 5'b00001;

    typedef struct packed {
        logic [7:0]  id;
        logic [4:0]  ca;
        logic [4:0]  cb;
        logic        chk;
        logic [15:0] sa;
        logic [15:0] fa;
        logic [3:0]  sb;
        logic [3:0]  fb;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;
    int   step_id  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int id,
                         input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s step=%0d got=%h want=%h", name, id, act, req);
        end
    endtask

    // Scoreboard monitor: one comparison set per driven cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("ctl_a", int'(mon_e.id), {11'd0, a_pc, a_ifw, a_fl, a_bub, a_hold}, {11'd0, mon_e.ca});
            check("ctl_b", int'(mon_e.id), {11'd0, b_pc, b_ifw, b_fl, b_bub, b_hold}, {11'd0, mon_e.cb});
            if (mon_e.chk) begin
                check("stall_a", int'(mon_e.id), a_stall, mon_e.sa);
                check("flush_a", int'(mon_e.id), a_flush, mon_e.fa);
                check("stall_b", int'(mon_e.id), {12'd0, b_stall}, {12'd0, mon_e.sb});
                check("flush_b", int'(mon_e.id), {12'd0, b_flush}, {12'd0, mon_e.fb});
            end
            $display("step %0d ctl_a=%b ctl_b=%b stall_a=%0d flush_a=%0d stall_b=%0d flush_b=%0d",
                     mon_e.id, {a_pc, a_ifw, a_fl, a_bub, a_hold},
                     {b_pc, b_ifw, b_fl, b_bub, b_hold}, a_stall, a_flush, b_stall, b_flush);
        end
    end

    // kind: 0 no load, 1 load-use on rs1, 2 x0 match, 3 load-use on rs2,
    //       4 register match but operands unused
    task automatic step(input logic rst, input int kind, input logic br, input logic mb,
                        input logic [4:0] ea, input logic [4:0] eb, input logic chk,
                        input int sa, input int fa, input int sb, input int fb);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        branch_taken = br;
        mem_busy     = mb;
        case (kind)
            1: begin ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd9; id_use_rs2 = 1'b1; end
            2: begin ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; id_rs2 = 5'd0; id_use_rs2 = 1'b1; end
            3: begin ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_use_rs1 = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1; end
            4: begin ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0; id_rs2 = 5'd5; id_use_rs2 = 1'b0; end
            default: begin ex_mem_read = 1'b0; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd0; id_use_rs2 = 1'b0; end
        endcase
        e.id  = 8'(step_id);
        e.ca  = ea;
        e.cb  = eb;
        e.chk = chk;
        e.sa  = 16'(sa);
        e.fa  = 16'(fa);
        e.sb  = 4'(sb);
        e.fb  = 4'(fb);
        exp_q.push_back(e);
        step_id++;
    endtask

    initial begin
        reset = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0;

        // Reset: idle outputs, counters cleared
        step(1, 0, 0, 0, IDLE, IDLE, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, IDLE, IDLE, 1, 0, 0, 0, 0);
        // Load-use: one stall, then suppressed
        step(0, 1, 0, 0, LU,   LU,   1, 0, 0, 0, 0);
        step(0, 1, 0, 0, IDLE, IDLE, 1, 1, 0, 1, 0);
        step(0, 0, 0, 0, IDLE, IDLE, 1, 1, 0, 1, 0);
        // Load-use with branch: branch wins
        step(0, 1, 1, 0, BR,   BR,   1, 1, 0, 1, 0);
        step(0, 1, 0, 0, LU,   FL,   1, 1, 1, 1, 1);
        step(0, 0, 0, 0, IDLE, FL,   1, 2, 1, 1, 1);
        step(0, 0, 0, 0, IDLE, IDLE, 1, 2, 1, 1, 1);
        // mem_busy x3 with branch in first cycle, serviced afterwards
        step(0, 0, 1, 1, MB,   MB,   1, 2, 1, 1, 1);
        step(0, 0, 0, 1, MB,   MB,   1, 3, 1, 2, 1);
        step(0, 0, 0, 1, MB,   MB,   1, 4, 1, 3, 1);
        step(0, 0, 0, 0, BR,   BR,   1, 5, 1, 4, 1);
        // mem_busy interrupts a multi-cycle flush; flush resumes
        step(0, 0, 0, 1, MB,   MB,   1, 5, 2, 4, 2);
        step(0, 0, 0, 0, IDLE, FL,   1, 6, 2, 5, 2);
        // Reset mid-flush discards remaining flush cycle
        step(1, 0, 0, 0, IDLE, IDLE, 1, 6, 2, 5, 2);
        step(0, 0, 0, 0, IDLE, IDLE, 1, 0, 0, 0, 0);
        // Reset in second flush cycle
        step(0, 0, 1, 0, BR,   BR,   1, 0, 0, 0, 0);
        step(1, 0, 0, 0, IDLE, IDLE, 1, 0, 1, 0, 1);
        step(0, 0, 0, 0, IDLE, IDLE, 1, 0, 0, 0, 0);
        // Clean branch: three flush cycles on u_b, bubble only in first
        step(0, 0, 1, 0, BR,   BR,   1, 0, 0, 0, 0);
        step(0, 0, 0, 0, IDLE, FL,   1, 0, 1, 0, 1);
        step(0, 0, 0, 0, IDLE, FL,   1, 0, 1, 0, 1);
        step(0, 0, 0, 0, IDLE, IDLE, 1, 0, 1, 0, 1);
        // Back-to-back branches restart the flush
        step(0, 0, 1, 0, BR,   BR,   1, 0, 1, 0, 1);
        step(0, 0, 1, 0, BR,   BR,   1, 0, 2, 0, 2);
        step(0, 0, 0, 0, IDLE, FL,   1, 0, 3, 0, 3);
        step(0, 0, 0, 0, IDLE, FL,   1, 0, 3, 0, 3);
        step(0, 0, 0, 0, IDLE, IDLE, 1, 0, 3, 0, 3);
        // x0 and unused operands never stall; rs2 dependency does
        step(0, 2, 0, 0, IDLE, IDLE, 1, 0, 3, 0, 3);
        step(0, 4, 0, 0, IDLE, IDLE, 1, 0, 3, 0, 3);
        step(0, 3, 0, 0, LU,   LU,   1, 0, 3, 0, 3);
        step(0, 0, 0, 0, IDLE, IDLE, 1, 1, 3, 1, 3);
        // Pending flush beats load-use when memory releases
        step(0, 1, 1, 1, MB,   MB,   1, 1, 3, 1, 3);
        step(0, 1, 0, 0, BR,   BR,   1, 2, 3, 2, 3);
        step(0, 1, 0, 0, LU,   FL,   1, 2, 4, 2, 4);
        step(0, 0, 0, 0, IDLE, FL,   1, 3, 4, 2, 4);
        // Load-use evaluated in the MEM_WAIT release cycle
        step(0, 1, 0, 1, MB,   MB,   1, 3, 4, 2, 4);
        step(0, 1, 0, 0, LU,   LU,   1, 4, 4, 3, 4);
        step(0, 0, 0, 0, IDLE, IDLE, 1, 5, 4, 4, 4);
        // 20 stall cycles: u_b stall counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 1, MB, MB, 1, 5 + i, 4, (4 + i > 15) ? 15 : 4 + i, 4);
        end
        step(0, 0, 0, 0, IDLE, IDLE, 1, 25, 4, 15, 4);
        step(0, 1, 0, 0, LU,   LU,   1, 25, 4, 15, 4);
        step(0, 0, 0, 0, IDLE, IDLE, 1, 26, 4, 15, 4);
        // 12 branches: u_b flush counter saturates at 15
        for (int j = 0; j < 12; j++) begin
            step(0, 0, 1, 0, BR, BR, 1, 26, 4 + j, 15, (4 + j > 15) ? 15 : 4 + j);
        end
        step(0, 0, 0, 0, IDLE, FL,   1, 26, 16, 15, 15);
        step(0, 0, 0, 0, IDLE, FL,   1, 26, 16, 15, 15);
        step(0, 0, 0, 0, IDLE, IDLE, 1, 26, 16, 15, 15);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, legal range 1..4: number of cycles ifid_flush is held per taken branch.
REQ-002 Parameter CNT_W, default 16: width of each performance counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_rs1, id_rs2  input  5 each  source register fields of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  input  1 each  ID instruction actually reads rs1 / rs2.
REQ-007 ex_rd  input  5  destination register of the instruction in EX.
REQ-008 ex_mem_read  input  1  EX instruction is a load.
REQ-009 branch_taken  input  1  EX resolved a taken branch or jump this cycle.
REQ-010 mem_busy  input  1  data memory is not completing this cycle; whole pipe must hold.
REQ-011 pc_write  output  1  PC may update.
REQ-012 ifid_write  output  1  IF/ID register may load.
REQ-013 ifid_flush  output  1  IF/ID loads a zero instruction (NOP).
REQ-014 idex_bubble  output  1  ID/EX loads a bubble (control bits zero).
REQ-015 pipe_hold  output  1  ID/EX, EX/MEM and MEM/WB hold their contents.
REQ-016 stall_cnt  output  CNT_W  count of cycles with pc_write=0.
REQ-017 flush_cnt  output  CNT_W  count of accepted branch flushes.

Function
REQ-018 The FSM SHALL have states RUN, LU_STALL, FLUSH, MEM_WAIT; outputs SHALL be combinational from state, pend_flush, flush counter and current inputs (zero-cycle latency).
REQ-019 Load-use hazard (LU) SHALL be ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
REQ-020 Priority each cycle SHALL be: mem_busy > (branch_taken | pend_flush) > FLUSH continuation > LU > idle.
REQ-021 mem_busy=1: pc_write=0, ifid_write=0, pipe_hold=1, ifid_flush=0, idex_bubble=0; next state MEM_WAIT; the flush counter SHALL freeze.
REQ-022 branch_taken=1 with mem_busy=1 SHALL set pend_flush; pend_flush SHALL be serviced as a branch in the first cycle mem_busy=0, then cleared.
REQ-023 Branch accepted (branch_taken|pend_flush, mem_busy=0): pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, pipe_hold=0; flush_cnt increments; LU SHALL be ignored.
REQ-024 After an accepted branch, if FLUSH_CYCLES>1 next state SHALL be FLUSH with a down-counter loaded with FLUSH_CYCLES-1; otherwise RUN.
REQ-025 In FLUSH (no mem_busy, no new branch): ifid_flush=1, idex_bubble=0, pc_write=1, ifid_write=1; counter decrements; return to RUN when it reaches 0. A new branch SHALL restart the sequence and increment flush_cnt.
REQ-026 LU in RUN or MEM_WAIT (mem_busy=0, no branch): pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, pipe_hold=0; next state LU_STALL.
REQ-027 In LU_STALL, LU SHALL be suppressed (exactly one stall cycle per load-use); outputs idle; next state RUN.
REQ-028 Idle outputs SHALL be pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_hold=0.
REQ-029 MEM_WAIT with mem_busy=0 SHALL evaluate the remaining priorities normally in that cycle.
REQ-030 Counters SHALL saturate at all-ones, never wrap.

Reset
REQ-031 reset=1 at a rising edge SHALL set state RUN, pend_flush=0, flush counter=0, stall_cnt=0, flush_cnt=0, overriding all other inputs that cycle.
REQ-032 While reset=1, outputs SHALL be the idle values of REQ-028; reset during FLUSH, MEM_WAIT or with pend_flush set SHALL discard that pending work.

Verification
REQ-033 ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle; next cycle idle; stall_cnt=1.
REQ-034 Same LU with branch_taken=1 -> ifid_flush=1, idex_bubble=1, pc_write=1; stall_cnt unchanged; flush_cnt=1.
REQ-035 mem_busy=1 for 3 cycles with branch_taken=1 in the first -> pipe_hold=1 and pc_write=0 for 3 cycles; 4th cycle ifid_flush=1, idex_bubble=1; stall_cnt=3, flush_cnt=1.
REQ-036 FLUSH_CYCLES=3, one branch -> ifid_flush=1 for 3 consecutive cycles, idex_bubble=1 only in the first; then idle.
REQ-037 ex_rd=0 with matching id_rs1=0, ex_mem_read=1 -> no stall; CNT_W=4 with 20 stall cycles -> stall_cnt=15.
REQ-038 reset=1 in the second FLUSH cycle (FLUSH_CYCLES=3) -> next cycle idle, counters 0.
